// File: rtl/vpe_pkg.sv
// Shared vector-engine defaults and saturation-limit helpers.
package vpe_pkg;

  localparam int EW_DEF    = 8;
  localparam int LANES_DEF = 8;
  localparam int IDX_W_DEF = 5;
  localparam int MUX_W_DEF = 2;

  // Largest positive value of an ew-bit two's complement number.
  function automatic logic [63:0] sat_max(input int ew);
    return (64'd1 << (ew - 1)) - 64'd1;
  endfunction

  // Most negative value of an ew-bit two's complement number.
  function automatic logic [63:0] sat_min(input int ew);
    return ~sat_max(ew);
  endfunction

endpackage

// File: rtl/vpe_vadd_lane.sv
// One EW-bit signed adder with overflow flag; clamps on overflow when
// VPE_VADD_SAT_EN is defined, otherwise wraps modulo 2^EW.
module vpe_vadd_lane
  import vpe_pkg::*;
#(
  parameter int EW = EW_DEF
) (
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [EW-1:0] y,
  output logic          ovf
);

  logic [EW-1:0] sum;

  assign sum = a + b;
  assign ovf = (a[EW-1] == b[EW-1]) && (sum[EW-1] != a[EW-1]);

`ifdef VPE_VADD_SAT_EN
  always_comb begin
    y = sum;
    if (ovf) y = a[EW-1] ? EW'(sat_min(EW)) : EW'(sat_max(EW));
  end
`else
  assign y = sum;
`endif

endmodule

// File: rtl/vpe_vector_reduce_tree.sv
// Pipelined binary-tree reduction of NUM_VEC vectors into one, lane-wise,
// with sideband, overflow and final-stage ReLU. Saturation: VPE_VADD_SAT_EN.
module vpe_vector_reduce_tree
  import vpe_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int LANES   = LANES_DEF,
  parameter int EW      = EW_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int MUX_W   = MUX_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_VEC*LANES*EW-1:0] i_data,
  input  logic                       i_data_v,
  output logic                       o_data_rdy,
  input  logic                       i_en_relu,
  input  logic [IDX_W-1:0]           i_rf_idx,
  input  logic [MUX_W-1:0]           i_rf_mux,
  output logic [LANES*EW-1:0]        o_data,
  output logic                       o_data_v,
  input  logic                       i_out_rdy,
  output logic                       o_ovf,
  output logic                       o_en_relu,
  output logic [IDX_W-1:0]           o_rf_idx,
  output logic [MUX_W-1:0]           o_rf_mux
);

  localparam int L  = $clog2(NUM_VEC);
  localparam int DW = NUM_VEC * LANES * EW;

  logic en;

  logic [DW-1:0]            in_d    [1:L];
  logic                     in_v    [1:L];
  logic                     in_relu [1:L];
  logic [IDX_W-1:0]         in_idx  [1:L];
  logic [MUX_W-1:0]         in_mux  [1:L];
  logic                     in_ovf  [1:L];

  logic [DW-1:0]            sum_w   [1:L];
  logic [NUM_VEC*LANES-1:0] ovf_w   [1:L];
  logic [DW-1:0]            nxt_d   [1:L];

  logic [DW-1:0]            data_q  [1:L];
  logic                     v_q     [1:L];
  logic                     relu_q  [1:L];
  logic [IDX_W-1:0]         idx_q   [1:L];
  logic [MUX_W-1:0]         mux_q   [1:L];
  logic                     ovf_q   [1:L];

  assign en         = !o_data_v || i_out_rdy;
  assign o_data_rdy = en;

  for (genvar s = 1; s <= L; s++) begin : g_stage
    localparam int NODES = NUM_VEC >> s;

    if (s == 1) begin : g_src_in
      assign in_d[s]    = i_data;
      assign in_v[s]    = i_data_v;
      assign in_relu[s] = i_en_relu;
      assign in_idx[s]  = i_rf_idx;
      assign in_mux[s]  = i_rf_mux;
      assign in_ovf[s]  = 1'b0;
    end else begin : g_src_prev
      assign in_d[s]    = data_q[s-1];
      assign in_v[s]    = v_q[s-1];
      assign in_relu[s] = relu_q[s-1];
      assign in_idx[s]  = idx_q[s-1];
      assign in_mux[s]  = mux_q[s-1];
      assign in_ovf[s]  = ovf_q[s-1];
    end

    // Node n of this level sums nodes 2n and 2n+1 of the level below.
    for (genvar n = 0; n < NODES; n++) begin : g_node
      for (genvar i = 0; i < LANES; i++) begin : g_lane
        vpe_vadd_lane #(.EW(EW)) u_add (
          .a   (in_d[s][((2*n)*LANES + i)*EW +: EW]),
          .b   (in_d[s][((2*n+1)*LANES + i)*EW +: EW]),
          .y   (sum_w[s][(n*LANES + i)*EW +: EW]),
          .ovf (ovf_w[s][n*LANES + i])
        );
      end
    end

    assign sum_w[s][DW-1:NODES*LANES*EW]           = '0;
    assign ovf_w[s][NUM_VEC*LANES-1:NODES*LANES] = '0;
  end

  // ReLU only touches the final level; overflow was already captured.
  always_comb begin
    for (int s = 1; s <= L; s++) nxt_d[s] = sum_w[s];
    if (in_relu[L]) begin
      for (int i = 0; i < LANES; i++) begin
        if (sum_w[L][i*EW + EW-1]) nxt_d[L][i*EW +: EW] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= L; s++) begin
        data_q[s] <= '0;
        v_q[s]    <= 1'b0;
        relu_q[s] <= 1'b0;
        idx_q[s]  <= '0;
        mux_q[s]  <= '0;
        ovf_q[s]  <= 1'b0;
      end
    end else if (en) begin
      for (int s = 1; s <= L; s++) begin
        data_q[s] <= nxt_d[s];
        v_q[s]    <= in_v[s];
        relu_q[s] <= in_relu[s];
        idx_q[s]  <= in_idx[s];
        mux_q[s]  <= in_mux[s];
        ovf_q[s]  <= in_ovf[s] | (|ovf_w[s]);
      end
    end
  end

  assign o_data    = data_q[L][LANES*EW-1:0];
  assign o_data_v  = v_q[L];
  assign o_ovf     = ovf_q[L];
  assign o_en_relu = relu_q[L];
  assign o_rf_idx  = idx_q[L];
  assign o_rf_mux  = mux_q[L];

endmodule

// File: doc/vpe_vector_reduce_tree.md
VPE_VECTOR_REDUCE_TREE -- requirements
Module: vpe_vector_reduce_tree

Interface
REQ-001 SHALL have parameter NUM_VEC, 4, number of input vectors reduced; a power of two, at least 2.
REQ-002 SHALL have parameter LANES, 8, elements per vector.
REQ-003 SHALL have parameter EW, 8, element width in bits, signed two's complement.
REQ-004 SHALL have parameter IDX_W, 5, register-file index width.
REQ-005 SHALL have parameter MUX_W, 2, register-file mux select width.
REQ-006 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port i_data  in  NUM_VEC*LANES*EW  packed vectors; vector k lane i at bits [(k*LANES+i)*EW +: EW].
REQ-009 SHALL have port i_data_v  in  1  input beat valid.
REQ-010 SHALL have port o_data_rdy  out  1  block accepts a beat this cycle.
REQ-011 SHALL have port i_en_relu / i_rf_idx / i_rf_mux  in  1/IDX_W/MUX_W  sideband attached to the beat.
REQ-012 SHALL have port o_data  out  LANES*EW  reduced vector, lane i at [i*EW +: EW].
REQ-013 SHALL have port o_data_v  out  1  output beat valid.
REQ-014 SHALL have port i_out_rdy  in  1  downstream accepts the output beat.
REQ-015 SHALL have port o_ovf  out  1  overflow occurred in any lane at any level of this beat.
REQ-016 SHALL have port o_en_relu / o_rf_idx / o_rf_mux  out  1/IDX_W/MUX_W  sideband aligned with o_data.

Function
REQ-017 SHALL compute o_data lane i = sum over k of vector k lane i, via a binary tree of L = log2(NUM_VEC) registered stages; stage s adds adjacent pairs of stage s-1 results.
REQ-018 SHALL keep every intermediate and final sum EW bits wide, with no width growth.
REQ-019 SHALL drive pipeline advance en = !o_data_v | i_out_rdy, with o_data_rdy = en; a beat is accepted when i_data_v & o_data_rdy.
REQ-020 SHALL have latency of exactly L cycles from acceptance to o_data_v when i_out_rdy is held high; throughput one beat per cycle.
REQ-021 SHALL freeze all stage data, valids and sidebands while en=0; o_data and all o_* SHALL then hold stable.
REQ-022 SHALL let invalid bubbles propagate so that stage valid[s] <= valid[s-1] when en=1; bubbles do not stall acceptance.
REQ-023 SHALL carry sideband and an OR-accumulated overflow bit in lockstep with each beat through every stage.
REQ-024 SHALL apply ReLU in the final stage when the beat's en_relu=1: lanes with negative sums become 0; o_ovf is unaffected by ReLU.
REQ-025 SHALL give NUM_VEC=2 a single stage, L=1.
REQ-026 SHALL raise a lane overflow when both operands share a sign and the EW-bit sum sign differs.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously clear all stage valids, data and sideband registers; o_data_v=0, o_data=0, o_ovf=0, o_en_relu=0, o_rf_idx=0, o_rf_mux=0.
REQ-028 SHALL discard in-flight beats when reset is asserted mid-operation; after release, o_data_rdy=1 on the first cycle.

Configuration
REQ-029 SHALL, with macro VPE_VADD_SAT_EN defined, clamp each overflowing add to +2^(EW-1)-1 or -2^(EW-1) before the next level.
REQ-030 SHALL, without VPE_VADD_SAT_EN, wrap modulo 2^EW; o_ovf is still reported in both builds.

Structure
REQ-031 SHALL take from shared package vpe_pkg the default widths (EW, LANES, IDX_W, MUX_W) and the saturation-limit helper functions.
REQ-032 SHALL instantiate one sub-module, vpe_vadd_lane: a combinational EW-bit signed add with wrap/saturate and an overflow flag, replicated per lane per tree node.

Verification
REQ-033 SHALL cover: defaults, lanes all 1,2,3,4 -> o_data lanes all 10 exactly 2 cycles later, o_ovf=0.
REQ-034 SHALL cover: lane0 vectors 100,100,0,0 -> wrap build gives -56, o_ovf=1; sat build gives 127, o_ovf=1.
REQ-035 SHALL cover: en_relu=1, lane sums -5 and 7 -> outputs 0 and 7; rf_idx=17, rf_mux=2 emerge with the same beat.
REQ-036 SHALL cover: back-to-back beats with i_out_rdy=0 for 3 cycles -> o_data stable, o_data_rdy=0, no beat lost or duplicated after release.
REQ-037 SHALL cover: reset asserted with 2 beats in flight -> all outputs 0 immediately; no stale beat after release.
REQ-038 SHALL cover: NUM_VEC=8, LANES=4 random stream vs reference model -> bit-exact, latency 3.
